// File: rtl/rr_select_mux.sv
// rr_select_mux
//   Round-robin arbiter feeding a one-entry registered output stage. CHANNELS
//   valid/ready producers compete. The winner is found by searching upward from
//   the round-robin pointer, wrapping past the last channel. The winning word is
//   loaded into the output register, which exposes a valid/ready interface to
//   the consumer.
//
//   Optional feature: define RR_SELECT_FORCE_EN to add force_en/force_sel. These
//   restrict granting to a single named channel without moving the pointer.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   [CHANNELS]        per-channel request
//   in_ready   out  [CHANNELS]        per-channel accept, one-hot or zero (comb)
//   in_data    in   [CHANNELS*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   out_valid  out  output register holds a word
//   out_ready  in   consumer accepts the output word
//   out_data   out  [WIDTH]           registered selected word
//   out_chan   out  [SEL_W]           channel that supplied out_data
//   force_en   in   (RR_SELECT_FORCE_EN only) restrict grant to force_sel
//   force_sel  in   [SEL_W] (RR_SELECT_FORCE_EN only) forced channel index
module rr_select_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan
`ifdef RR_SELECT_FORCE_EN
  ,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel
`endif
);

  logic [SEL_W-1:0] ptr;
  logic             space;
  logic             found;
  logic             forced;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   scan_idx;
  logic [SEL_W-1:0] scan_sel;
  logic [WIDTH-1:0] sel_data;
  logic             transfer;

  assign space = !out_valid || out_ready;

  // Round-robin search. scan_idx is one bit wider than ptr so ptr+k never
  // overflows before the wrap subtraction.
  always_comb begin
    found     = 1'b0;
    forced    = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    scan_sel  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      scan_idx = {1'b0, ptr} + (SEL_W+1)'(k);
      if (scan_idx >= (SEL_W+1)'(CHANNELS))
        scan_idx = scan_idx - (SEL_W+1)'(CHANNELS);
      scan_sel = scan_idx[SEL_W-1:0];
      if (!found && in_valid[scan_sel]) begin
        found     = 1'b1;
        grant_idx = scan_sel;
      end
    end
`ifdef RR_SELECT_FORCE_EN
    // Matching by compare keeps an out-of-range force_sel from indexing past
    // in_valid. Such a value simply matches nothing.
    if (force_en) begin
      forced    = 1'b1;
      found     = 1'b0;
      grant_idx = force_sel;
      for (int c = 0; c < CHANNELS; c++) begin
        if (force_sel == SEL_W'(c) && in_valid[c])
          found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (space && found && !reset)
      in_ready[grant_idx] = 1'b1;
  end

  assign transfer = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_idx == SEL_W'(c))
        sel_data = in_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (transfer) begin
      // Covers both a plain load and a drain-plus-refill in the same cycle.
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= grant_idx;
      if (!forced)
        ptr <= (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_select_mux.sv
module tb_rr_select_mux;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk;
  logic                      reset;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
`ifdef RR_SELECT_FORCE_EN
  logic                      force_en;
  logic [SEL_W-1:0]          force_sel;
`endif

  int checks   = 0;
  int failures = 0;

  rr_select_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
`ifdef RR_SELECT_FORCE_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h chan=%0d ready=%b required 0/0/0/0",
               out_valid, out_data, out_chan, in_ready);
    end
    for (int i = 0; i < CHANNELS; i++) set_data(i, 32'hA0 + i);
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant: in_ready=%b required 0001", in_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [CHANNELS-1:0] exp_ready;
    for (int i = 0; i < 5; i++) begin
      exp_ready = '0;
      exp_ready[i % CHANNELS] = 1'b1;
      #1;
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL rr_grant[%0d]: in_ready=%b required %b", i, in_ready, exp_ready);
      end
      after_edge();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0 + (i % CHANNELS) ||
          out_chan !== SEL_W'(i % CHANNELS)) begin
        failures++;
        $display("FAIL rr_out[%0d]: valid=%b data=%h chan=%0d required 1/%h/%0d",
                 i, out_valid, out_data, out_chan, 32'hA0 + (i % CHANNELS), i % CHANNELS);
      end
    end
    @(negedge clk);
    in_valid = '0;
    after_edge();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hA0) begin
      failures++;
      $display("FAIL rr_drain: valid=%b data=%h required 0/000000a0", out_valid, out_data);
    end
  endtask

  // Pointer is 1 on entry.
  task automatic test_single_channel();
    @(negedge clk);
    set_data(2, 32'h1234);
    in_valid = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant_a: in_ready=%b required 0100", in_ready);
    end
    after_edge();
    checks++;
    if (dut.ptr !== 2'd3) begin
      failures++;
      $display("FAIL single_ptr_a: ptr=%0d required 3", dut.ptr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant_ptr3: in_ready=%b required 0100", in_ready);
    end
    after_edge();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_chan !== 2'd2 || dut.ptr !== 2'd3) begin
      failures++;
      $display("FAIL single_out: valid=%b data=%h chan=%0d ptr=%0d required 1/1234/2/3",
               out_valid, out_data, out_chan, dut.ptr);
    end
    @(negedge clk);
    set_data(3, 32'h3333);
    in_valid = 4'b1000;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_grant: in_ready=%b required 1000", in_ready);
    end
    after_edge();
    checks++;
    if (out_data !== 32'h3333 || out_chan !== 2'd3 || dut.ptr !== 2'd0) begin
      failures++;
      $display("FAIL wrap_out: data=%h chan=%0d ptr=%0d required 3333/3/0",
               out_data, out_chan, dut.ptr);
    end
    @(negedge clk);
    in_valid = '0;
    after_edge();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h3333 || out_chan !== 2'd3 || dut.ptr !== 2'd0) begin
      failures++;
      $display("FAIL stale_hold: valid=%b data=%h chan=%0d ptr=%0d required 0/3333/3/0",
               out_valid, out_data, out_chan, dut.ptr);
    end
  endtask

  // Pointer is 0 on entry.
  task automatic test_stall();
    @(negedge clk);
    set_data(0, 32'h5555);
    in_valid = 4'b0001;
    after_edge();
    @(negedge clk);
    out_ready = 1'b0;
    set_data(1, 32'h6666);
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL stall_ready[%0d]: in_ready=%b required 0000", i, in_ready);
      end
      after_edge();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h5555 || out_chan !== 2'd0 || dut.ptr !== 2'd1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h chan=%0d ptr=%0d required 1/5555/0/1",
                 i, out_valid, out_data, out_chan, dut.ptr);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL refill_grant: in_ready=%b required 0010", in_ready);
    end
    after_edge();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h6666 || out_chan !== 2'd1) begin
      failures++;
      $display("FAIL refill_out: valid=%b data=%h chan=%0d required 1/6666/1",
               out_valid, out_data, out_chan);
    end
    @(negedge clk);
    in_valid = '0;
    after_edge();
  endtask

  // Pointer is 2 on entry.
  task automatic test_reset_discard();
    @(negedge clk);
    set_data(2, 32'hDEAD);
    in_valid = 4'b0100;
    out_ready = 1'b0;
    after_edge();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD) begin
      failures++;
      $display("FAIL discard_load: valid=%b data=%h required 1/dead", out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%b data=%h chan=%0d ready=%b required 0/0/0/0",
               out_valid, out_data, out_chan, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      checks++;
      if (out_valid !== 1'b0 || out_data === 32'hDEAD) begin
        failures++;
        $display("FAIL discard_gone[%0d]: valid=%b data=%h required 0/not dead",
                 i, out_valid, out_data);
      end
    end
    @(negedge clk);
    for (int i = 0; i < CHANNELS; i++) set_data(i, 32'hB0 + i);
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_grant: in_ready=%b required 0001", in_ready);
    end
    after_edge();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hB0 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_out: valid=%b data=%h chan=%0d required 1/b0/0",
               out_valid, out_data, out_chan);
    end
    @(negedge clk);
    in_valid = '0;
    after_edge();
  endtask

`ifdef RR_SELECT_FORCE_EN
  // Pointer is 1 on entry.
  task automatic test_force();
    @(negedge clk);
    for (int i = 0; i < CHANNELS; i++) set_data(i, 32'hC0 + i);
    in_valid = 4'b1111;
    force_en = 1'b1;
    force_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
        failures++;
        $display("FAIL force_grant[%0d]: in_ready=%b required 1000", i, in_ready);
      end
      after_edge();
      checks++;
      if (out_chan !== 2'd3 || out_data !== 32'hC3 || dut.ptr !== 2'd1) begin
        failures++;
        $display("FAIL force_out[%0d]: chan=%0d data=%h ptr=%0d required 3/c3/1",
                 i, out_chan, out_data, dut.ptr);
      end
      @(negedge clk);
    end
    force_en = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL force_release: in_ready=%b required 0010", in_ready);
    end
    in_valid = '0;
    after_edge();
  endtask
`endif

  initial begin
`ifdef RR_SELECT_FORCE_EN
    force_en = 1'b0;
    force_sel = '0;
`endif
    test_reset();
    test_round_robin();
    test_single_channel();
    test_stall();
    test_reset_discard();
`ifdef RR_SELECT_FORCE_EN
    test_force();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
